// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared FSM state, priority and counter-width definitions for pong_sound_fx
// ST_TONE2 is only declared when SOUND_SCORE_SWEEP_EN is defined.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1
`ifdef SOUND_SCORE_SWEEP_EN
        , ST_TONE2 = 2'd2
`endif
    } fx_state_t;

    localparam logic [1:0] PRI_WALL   = 2'd0;
    localparam logic [1:0] PRI_PADDLE = 2'd1;
    localparam logic [1:0] PRI_SCORE  = 2'd2;

    localparam int HALF_W = 18;
    localparam int PRE_W  = 17;
    localparam int MS_W   = 9;

endpackage

// File: rtl/sound_tone_counter.sv
// rtl/sound_tone_counter.sv - loadable half-period divider producing the square-wave tone bit
// load restarts the divider with a cleared tone bit; clear parks it at zero.
module sound_tone_counter
    import pong_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [HALF_W-1:0] half,
    output logic              tone
);

    logic [HALF_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tone  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tone  <= 1'b0;
        end else if (load) begin
            count <= half - 1'b1;
            tone  <= 1'b0;
        end else if (count == '0) begin
            count <= half - 1'b1;
            tone  <= ~tone;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pong_sound_fx.sv
// rtl/pong_sound_fx.sv - prioritised, preemptible sound-effect player driving the speaker pin
// SOUND_SCORE_SWEEP_EN: score plays a two-note falling jingle (TONE then TONE2).
module pong_sound_fx
    import pong_pkg::*;
#(
    parameter int unsigned MS_CYCLES   = 100000,
    parameter int unsigned PADDLE_HALF = 113636,
    parameter int unsigned WALL_HALF   = 227272,
    parameter int unsigned SCORE_HALF  = 56818,
    parameter int unsigned PADDLE_MS   = 50,
    parameter int unsigned WALL_MS     = 30,
    parameter int unsigned SCORE_MS    = 250
) (
    input  logic Clock,
    input  logic Reset,
    input  logic paddleHit,
    input  logic wallHit,
    input  logic score,
    input  logic mute,
    output logic Speaker,
    output logic busy
);

`ifdef SOUND_SCORE_SWEEP_EN
    localparam int unsigned SCORE_TONE_MS = SCORE_MS / 2;
    localparam logic [MS_W-1:0] SWEEP2_DUR = MS_W'(SCORE_MS / 2 - 1);
`else
    localparam int unsigned SCORE_TONE_MS = SCORE_MS;
`endif

    if (MS_CYCLES < 1 || MS_CYCLES > 2**PRE_W) begin : g_bad_ms_cycles
        $error("MS_CYCLES does not fit the prescaler");
    end
    if (PADDLE_HALF < 1 || PADDLE_HALF >= 2**HALF_W || WALL_HALF < 1 || WALL_HALF >= 2**HALF_W
        || SCORE_HALF < 1 || SCORE_HALF >= 2**HALF_W) begin : g_bad_half
        $error("half-period parameter does not fit the tone counter");
    end
    if (PADDLE_MS < 1 || PADDLE_MS > 2**MS_W || WALL_MS < 1 || WALL_MS > 2**MS_W
        || SCORE_TONE_MS < 1 || SCORE_TONE_MS > 2**MS_W) begin : g_bad_ms
        $error("effect duration does not fit the ms counter");
    end

    localparam logic [HALF_W-1:0] PADDLE_H = HALF_W'(PADDLE_HALF);
    localparam logic [HALF_W-1:0] WALL_H   = HALF_W'(WALL_HALF);
    localparam logic [HALF_W-1:0] SCORE_H  = HALF_W'(SCORE_HALF);
    localparam logic [PRE_W-1:0]  PRE_LOAD = PRE_W'(MS_CYCLES - 1);

    fx_state_t         state, state_next;
    logic              prev_paddle, prev_wall, prev_score;
    logic              ev_paddle, ev_wall, ev_score, ev_any;
    logic [1:0]        ev_pri, cur_pri;
    logic [HALF_W-1:0] ev_half, cur_half, load_half;
    logic [MS_W-1:0]   ev_dur, ms_cnt;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick, done, start, to_tone2, tone;

    assign ev_paddle = paddleHit & ~prev_paddle;
    assign ev_wall   = wallHit & ~prev_wall;
    assign ev_score  = score & ~prev_score;
    assign ev_any    = ev_paddle | ev_wall | ev_score;
    assign tick      = (pre_cnt == '0);
    assign done      = tick && (ms_cnt == '0);

    always_comb begin
        ev_pri  = PRI_WALL;
        ev_half = WALL_H;
        ev_dur  = MS_W'(WALL_MS - 1);
        if (ev_score) begin
            ev_pri  = PRI_SCORE;
            ev_half = SCORE_H;
            ev_dur  = MS_W'(SCORE_TONE_MS - 1);
        end else if (ev_paddle) begin
            ev_pri  = PRI_PADDLE;
            ev_half = PADDLE_H;
            ev_dur  = MS_W'(PADDLE_MS - 1);
        end
    end

    // Equal priority also restarts, so a repeated hit replays its effect from the top.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        to_tone2   = 1'b0;
        if (ev_any && (state == ST_IDLE || ev_pri >= cur_pri)) begin
            start      = 1'b1;
            state_next = ST_TONE;
        end else if (state != ST_IDLE && done) begin
`ifdef SOUND_SCORE_SWEEP_EN
            if (state == ST_TONE && cur_pri == PRI_SCORE) begin
                to_tone2   = 1'b1;
                state_next = ST_TONE2;
            end else
`endif
                state_next = ST_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            prev_paddle <= 1'b0;
            prev_wall   <= 1'b0;
            prev_score  <= 1'b0;
            cur_pri     <= PRI_WALL;
            cur_half    <= '0;
            pre_cnt     <= '0;
            ms_cnt      <= '0;
        end else begin
            state       <= state_next;
            prev_paddle <= paddleHit;
            prev_wall   <= wallHit;
            prev_score  <= score;
            if (start) begin
                cur_pri  <= ev_pri;
                cur_half <= ev_half;
                pre_cnt  <= PRE_LOAD;
                ms_cnt   <= ev_dur;
`ifdef SOUND_SCORE_SWEEP_EN
            end else if (to_tone2) begin
                cur_half <= PADDLE_H;
                pre_cnt  <= PRE_LOAD;
                ms_cnt   <= SWEEP2_DUR;
`endif
            end else if (state_next == ST_IDLE) begin
                cur_pri  <= PRI_WALL;
                cur_half <= '0;
                pre_cnt  <= '0;
                ms_cnt   <= '0;
            end else begin
                pre_cnt <= tick ? PRE_LOAD : pre_cnt - 1'b1;
                if (tick) ms_cnt <= ms_cnt - 1'b1;
            end
        end
    end

    assign load_half = start ? ev_half : (to_tone2 ? PADDLE_H : cur_half);

    sound_tone_counter u_tone (
        .clk   (Clock),
        .rst_n (Reset),
        .clear (state_next == ST_IDLE),
        .load  (start | to_tone2),
        .half  (load_half),
        .tone  (tone)
    );

    assign Speaker = tone & ~mute;
    assign busy    = (state != ST_IDLE);

endmodule

// File: doc/pong_sound_fx.md
# pong_sound_fx

Sound-effect generator for the Pong-with-sound game: converts one-cycle game event strobes (paddle hit, wall bounce, score) into a timed square-wave tone on the speaker pin. It sits directly downstream of the game logic and drives the board `Speaker` output. It replaces ad-hoc tone code inside the game module with a prioritised, preemptible effect player.

## Interface
- `MS_CYCLES`, 100000: clock cycles per millisecond tick (100 MHz system clock).
- `PADDLE_HALF`, 113636: half-period in cycles for the paddle tone (440 Hz).
- `WALL_HALF`, 227272: half-period for the wall tone (220 Hz).
- `SCORE_HALF`, 56818: half-period for the score tone (880 Hz).
- `PADDLE_MS`, 50; `WALL_MS`, 30; `SCORE_MS`, 250: effect durations in ms.
- `Clock`  in  1  system clock, 100 MHz.
- `Reset`  in  1  asynchronous, active-low reset.
- `paddleHit`  in  1  event strobe, synchronous to `Clock`.
- `wallHit`  in  1  event strobe.
- `score`  in  1  event strobe.
- `mute`  in  1  level; forces `Speaker` low, timing continues.
- `Speaker`  out  1  square-wave output.
- `busy`  out  1  high while an effect is playing.

## Operation
- Inputs are edge-detected internally (registered previous value); only a 0→1 transition is an event, so held-high inputs trigger once.
- Priority: score (2) > paddle (1) > wall (0). Simultaneous events: highest wins; others discarded.
- FSM states: IDLE, TONE, TONE2 (TONE2 exists only with the macro below).
- IDLE: `Speaker`=0, `busy`=0, counters cleared. Any event → TONE, loading that effect's half-period, duration and priority.
- TONE: half-period counter counts down from `HALF-1`; at 0 toggle internal tone bit and reload. Prescaler counts `MS_CYCLES` cycles per ms tick; ms counter counts down from `DUR` on each tick. At ms counter 0 on a tick → IDLE (or TONE2 for a sweeping score).
- Preemption: an event with priority ≥ current priority restarts the effect from the beginning (all counters reloaded, tone bit cleared). A lower-priority event during playback is ignored.
- `Speaker` = tone bit AND NOT `mute`.
- Widths: half-period counter 18 bits, prescaler 17 bits, ms counter 9 bits. Parameters exceeding these widths are a configuration error (elaboration-time check).
- Reset (any time, including mid-effect): state IDLE, `Speaker`=0, `busy`=0, edge-detect registers 0, all counters 0.

## Timing
- Event edge at input in cycle N is detected in cycle N; state = TONE and `busy`=1 from cycle N+1.
- First `Speaker` rise at cycle N+1+HALF; toggles every HALF cycles thereafter.
- Effect length = DUR×MS_CYCLES cycles (±1); `busy` falls and `Speaker` forced 0 on the cycle after the final tick.
- `mute` acts combinationally on the registered tone bit: `Speaker` follows it within the same cycle.

## Configuration
- `SOUND_SCORE_SWEEP_EN` defined: the score effect plays SCORE_HALF for SCORE_MS/2 ms (TONE), then PADDLE_HALF for SCORE_MS/2 ms (TONE2), a falling two-note jingle. A score event in TONE2 restarts at TONE. TONE2 → IDLE on completion.
- Undefined: score is a single SCORE_HALF tone for SCORE_MS ms; TONE2 is not built.

## Structure
- Shared package `pong_pkg`: FSM state enum, priority encoding constants (`PRI_WALL`, `PRI_PADDLE`, `PRI_SCORE`), counter width constants.
- One sub-module, `sound_tone_counter`: loadable half-period divider producing the tone bit, with `load` and `half` inputs. FSM, priority arbitration and duration timing remain in `pong_sound_fx`.

## Test plan
Bench overrides: MS_CYCLES=10, PADDLE_HALF=4, WALL_HALF=6, SCORE_HALF=2, PADDLE_MS=3, WALL_MS=2, SCORE_MS=4.
- Reset release, no events → `Speaker`=0, `busy`=0 for 200 cycles.
- `paddleHit` pulse at cycle 10 → `busy` high cycles 11–40, `Speaker` toggles every 4 cycles starting cycle 15, low afterwards.
- `wallHit` and `score` asserted in the same cycle → score tone (period 4 cycles) plays; wall discarded.
- `score` playing, `wallHit` pulse mid-effect → ignored, effect ends on schedule. `paddleHit` playing, then `score` pulse → restart as score, `busy` extended by 40 cycles.
- `mute` high during paddle effect → `Speaker`=0, `busy` unaffected. Drop `mute` → `Speaker` resumes in phase. `Reset` asserted mid-effect → `Speaker`=0, `busy`=0 immediately, asynchronously.
- With `SOUND_SCORE_SWEEP_EN` → `score` gives 20 cycles at period 4 then 20 cycles at period 8. Without the macro → 40 cycles at period 4. Held-high `paddleHit` for 100 cycles → exactly one effect.
